// File: rtl/uart_rx_os.sv
// 16x-oversampled UART receiver: 2-flop rx synchroniser, mid-bit start qualification,
// centre sampling of data/parity/stop, and a 1-deep valid/ready holding register.
`timescale 1ns/1ps
module uart_rx_os #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_tick,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       parity_err,
  output logic       break_det,
  output logic       overrun,
  output logic       busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE/2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state_q, state_d;
  logic          rx_meta_q, rxs_q;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_q, par_d;
  logic          brk_wait_q, brk_wait_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          perr_q, perr_d;
  logic          brk_q, brk_d;
  logic          ovr_q, ovr_d;

  logic [7:0] frm_data;
  logic       frm_ferr, frm_perr, frm_brk;
  logic       done, take, xfer;

  // Received bits enter at bit 7, so the frame ends up in the top DATA_BITS bits.
  assign frm_data = shreg_q >> (8 - DATA_BITS);
  assign frm_ferr = !rxs_q;
  assign frm_perr = (PARITY_EN != 0) && ((^frm_data) ^ par_q ^ (PARITY_ODD != 0));
  assign frm_brk  = (frm_data == 8'd0) && !rxs_q && ((PARITY_EN == 0) || !par_q);

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    brk_wait_d = brk_wait_q;
    done       = 1'b0;
    if (sample_tick) begin
      case (state_q)
        IDLE: begin
          if (brk_wait_q) begin
            if (rxs_q) brk_wait_d = 1'b0;
          end else if (!rxs_q) begin
            tick_d  = '0;
            state_d = START;
          end
        end
        START: begin
          if (tick_q == TICK_MID) begin
            if (!rxs_q) begin
              tick_d  = '0;
              bit_d   = 3'd0;
              state_d = DATA;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        DATA: begin
          tick_d = tick_q + 1'b1;
          if (tick_q == TICK_LAST) begin
            shreg_d = {rxs_q, shreg_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == BIT_LAST) state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
        PARITY: begin
          tick_d = tick_q + 1'b1;
          if (tick_q == TICK_LAST) begin
            par_d   = rxs_q;
            state_d = STOP;
          end
        end
        STOP: begin
          tick_d = tick_q + 1'b1;
          // Back to IDLE at the stop-bit centre so an immediately following start bit is caught.
          if (tick_q == TICK_LAST) begin
            done       = 1'b1;
            brk_wait_d = frm_brk;
            state_d    = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign xfer = valid_q && rx_ready;
  assign take = done && (!valid_q || rx_ready);

  always_comb begin
    data_d  = data_q;
    ferr_d  = ferr_q;
    perr_d  = perr_q;
    brk_d   = brk_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (take) begin
      data_d  = frm_data;
      ferr_d  = frm_ferr;
      perr_d  = frm_perr;
      brk_d   = frm_brk;
      valid_d = 1'b1;
    end else if (xfer) begin
      valid_d = 1'b0;
    end
    if (done && !take) ovr_d = 1'b1;
    else if (xfer)     ovr_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      state_q    <= IDLE;
      tick_q     <= '0;
      bit_q      <= 3'd0;
      shreg_q    <= 8'd0;
      par_q      <= 1'b0;
      brk_wait_q <= 1'b0;
      data_q     <= 8'd0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
      brk_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      rx_meta_q  <= rx;
      rxs_q      <= rx_meta_q;
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      brk_wait_q <= brk_wait_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      perr_q     <= perr_d;
      brk_q      <= brk_d;
      ovr_q      <= ovr_d;
    end
  end

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign frame_err  = ferr_q;
  assign parity_err = perr_q;
  assign break_det  = brk_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: a default-parameter receiver and an even-parity receiver.
`timescale 1ns/1ps
module tb_uart_rx_os;

  localparam int TICK_DIV = 27;
  localparam int BITCLK   = 16 * TICK_DIV;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tick = 1'b0;
  logic rx_a = 1'b1;
  logic rx_p = 1'b1;
  logic rdy_a = 1'b1;

  logic [7:0] data_a, data_p;
  logic vld_a, ferr_a, perr_a, brk_a, ovr_a, busy_a;
  logic vld_p, ferr_p, perr_p, brk_p, ovr_p, busy_p;

  int n_cmp = 0;
  int n_fail = 0;
  logic [10:0] q_a[$];
  logic [10:0] q_p[$];
  logic tick_seen = 1'b0;
  logic pv_a = 1'b0;
  logic pv_p = 1'b0;

  always #5 clk = ~clk;

  uart_rx_os dut (
    .clk(clk), .rst(rst), .sample_tick(tick), .rx(rx_a),
    .rx_data(data_a), .rx_valid(vld_a), .rx_ready(rdy_a),
    .frame_err(ferr_a), .parity_err(perr_a), .break_det(brk_a),
    .overrun(ovr_a), .busy(busy_a)
  );

  uart_rx_os #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
    .clk(clk), .rst(rst), .sample_tick(tick), .rx(rx_p),
    .rx_data(data_p), .rx_valid(vld_p), .rx_ready(1'b1),
    .frame_err(ferr_p), .parity_err(perr_p), .break_det(brk_p),
    .overrun(ovr_p), .busy(busy_p)
  );

  initial begin : tickgen
    int c;
    c = 0;
    forever begin
      @(posedge clk);
      #2;
      c = (c == TICK_DIV - 1) ? 0 : c + 1;
      tick = (c == 0);
    end
  end

  always @(posedge clk) tick_seen <= tick;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [10:0] mk(input logic [7:0] d, input logic f, input logic p, input logic b);
    return {b, p, f, d};
  endfunction

  // Monitor: every accepted frame is popped from its scoreboard and compared.
  always @(negedge clk) begin
    if (rst) begin
      if (vld_a && !pv_a) chk("latency_a", {31'd0, tick_seen}, 32'd1);
      if (vld_p && !pv_p) chk("latency_p", {31'd0, tick_seen}, 32'd1);
      pv_a = vld_a;
      pv_p = vld_p;
      if (vld_a && rdy_a) begin
        if (q_a.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL frame_a: got unexpected frame %0h, expected none", {brk_a, perr_a, ferr_a, data_a});
        end else begin
          chk("frame_a", {21'd0, brk_a, perr_a, ferr_a, data_a}, {21'd0, q_a.pop_front()});
        end
      end
      if (vld_p) begin
        if (q_p.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL frame_p: got unexpected frame %0h, expected none", {brk_p, perr_p, ferr_p, data_p});
        end else begin
          chk("frame_p", {21'd0, brk_p, perr_p, ferr_p, data_p}, {21'd0, q_p.pop_front()});
        end
      end
    end else begin
      pv_a = 1'b0;
      pv_p = 1'b0;
    end
  end

  task automatic drv(input bit which, input logic v, input int n);
    @(posedge clk);
    #2;
    if (which) rx_p = v;
    else       rx_a = v;
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic send(input bit which, input logic [7:0] d, input bit has_par, input logic par, input bit stop_ok);
    drv(which, 1'b0, BITCLK);
    for (int i = 0; i < 8; i++) drv(which, d[i], BITCLK);
    if (has_par) drv(which, par, BITCLK);
    if (stop_ok) begin
      drv(which, 1'b1, BITCLK);
    end else begin
      drv(which, 1'b0, 270);
      drv(which, 1'b1, BITCLK - 270);
    end
  endtask

  initial begin
    logic [7:0] d81;
    d81 = 8'h81;
    repeat (5) @(posedge clk);
    #3;
    chk("rst_valid", {31'd0, vld_a}, 32'd0);
    chk("rst_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_overrun", {31'd0, ovr_a}, 32'd0);
    chk("rst_data", {24'd0, data_a}, 32'd0);
    @(posedge clk); #2; rst = 1'b1;
    drv(0, 1'b1, BITCLK);

    q_a.push_back(mk(8'h55, 1'b0, 1'b0, 1'b0));
    send(0, 8'h55, 0, 1'b0, 1);
    drv(0, 1'b1, BITCLK);

    drv(0, 1'b0, 4 * TICK_DIV);
    chk("glitch_busy_hi", {31'd0, busy_a}, 32'd1);
    drv(0, 1'b1, 10 * TICK_DIV);
    chk("glitch_busy_lo", {31'd0, busy_a}, 32'd0);
    chk("glitch_valid", {31'd0, vld_a}, 32'd0);
    drv(0, 1'b1, BITCLK);
    q_a.push_back(mk(8'hA5, 1'b0, 1'b0, 1'b0));
    send(0, 8'hA5, 0, 1'b0, 1);
    drv(0, 1'b1, BITCLK);

    q_a.push_back(mk(8'h3C, 1'b1, 1'b0, 1'b0));
    send(0, 8'h3C, 0, 1'b0, 0);
    drv(0, 1'b1, BITCLK);

    q_a.push_back(mk(8'h00, 1'b1, 1'b0, 1'b1));
    drv(0, 1'b0, 11 * BITCLK + 216);
    chk("break_idle_hold", {31'd0, busy_a}, 32'd0);
    drv(0, 1'b0, 216);
    drv(0, 1'b1, 2 * BITCLK);

    @(posedge clk); #2; rdy_a = 1'b0;
    q_a.push_back(mk(8'h11, 1'b0, 1'b0, 1'b0));
    send(0, 8'h11, 0, 1'b0, 1);
    send(0, 8'h22, 0, 1'b0, 1);
    drv(0, 1'b1, BITCLK);
    chk("ovr_valid", {31'd0, vld_a}, 32'd1);
    chk("ovr_data", {24'd0, data_a}, 32'h11);
    chk("ovr_flag", {31'd0, ovr_a}, 32'd1);
    @(posedge clk); #2; rdy_a = 1'b1;
    @(posedge clk); #2; rdy_a = 1'b0;
    chk("ovr_valid_clr", {31'd0, vld_a}, 32'd0);
    chk("ovr_flag_clr", {31'd0, ovr_a}, 32'd0);

    send(0, 8'h81, 0, 1'b0, 1);
    send(0, 8'h81, 0, 1'b0, 1);
    drv(0, 1'b0, BITCLK);
    for (int i = 0; i < 4; i++) drv(0, d81[i], BITCLK);
    drv(0, d81[4], 200);
    chk("pre_rst_valid", {31'd0, vld_a}, 32'd1);
    chk("pre_rst_busy", {31'd0, busy_a}, 32'd1);
    chk("pre_rst_ovr", {31'd0, ovr_a}, 32'd1);
    #3; rst = 1'b0; rx_a = 1'b1;
    #1;
    chk("arst_valid", {31'd0, vld_a}, 32'd0);
    chk("arst_data", {24'd0, data_a}, 32'd0);
    chk("arst_busy", {31'd0, busy_a}, 32'd0);
    chk("arst_ovr", {31'd0, ovr_a}, 32'd0);
    chk("arst_flags", {29'd0, ferr_a, perr_a, brk_a}, 32'd0);
    repeat (3) @(posedge clk);
    #2; rst = 1'b1; rdy_a = 1'b1;
    drv(0, 1'b1, BITCLK);
    q_a.push_back(mk(8'h81, 1'b0, 1'b0, 1'b0));
    send(0, 8'h81, 0, 1'b0, 1);
    drv(0, 1'b1, BITCLK);

    q_p.push_back(mk(8'h07, 1'b0, 1'b1, 1'b0));
    send(1, 8'h07, 1, 1'b0, 1);
    drv(1, 1'b1, BITCLK);
    q_p.push_back(mk(8'h07, 1'b0, 1'b0, 1'b0));
    send(1, 8'h07, 1, 1'b1, 1);
    drv(1, 1'b1, BITCLK);

    chk("q_a_drained", q_a.size(), 32'd0);
    chk("q_p_drained", q_p.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
